// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE dot-product accumulator.
package pe_pkg;

   localparam int ACC_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } pe_state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned adder that clamps to all-ones instead of wrapping.
module sat_add #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         sat
);

   logic [W:0] full;

   assign full = {1'b0, a} + {1'b0, b};
   assign sat  = full[W];
   assign sum  = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/pe_accumulator.sv
// Accumulates a fixed-length stream of PE products into a saturating sum
// and holds the result until downstream takes it.
module pe_accumulator
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [LEN_WIDTH-1:0]    len,
   input  logic                    prod_valid,
   input  logic [2*DATA_WIDTH-1:0] prod_data,
   output logic                    prod_ready,
   output logic                    acc_valid,
   output logic [ACC_WIDTH-1:0]    acc_data,
   output logic                    acc_sat,
   input  logic                    acc_ready,
   output logic                    busy
);

   pe_state_t            state, state_nxt;
   logic [ACC_WIDTH-1:0] sum_q, sum_nxt, add_sum, prod_ext;
   logic [LEN_WIDTH-1:0] rem_q, rem_nxt;
   logic                 sat_q, sat_nxt, add_sat;

   assign prod_ext = ACC_WIDTH'(prod_data);

   sat_add #(.W(ACC_WIDTH)) u_sat_add (
      .a   (sum_q),
      .b   (prod_ext),
      .sum (add_sum),
      .sat (add_sat)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sum_q <= '0;
         rem_q <= '0;
         sat_q <= 1'b0;
      end else begin
         state <= state_nxt;
         sum_q <= sum_nxt;
         rem_q <= rem_nxt;
         sat_q <= sat_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sum_nxt   = sum_q;
      rem_nxt   = rem_q;
      sat_nxt   = sat_q;
      case (state)
         IDLE: begin
            if (start) begin
               rem_nxt   = len;
               sum_nxt   = '0;
               sat_nxt   = 1'b0;
               state_nxt = (len == '0) ? DRAIN : ACCUM;
            end
         end
         ACCUM: begin
            if (prod_valid) begin
               sum_nxt = add_sum;
               sat_nxt = sat_q | add_sat;
               rem_nxt = rem_q - LEN_WIDTH'(1);
               // last beat: result becomes visible on the very next cycle
               if (rem_q == LEN_WIDTH'(1)) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (acc_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // All handshake outputs decode registered state only.
   assign prod_ready = (state == ACCUM);
   assign acc_valid  = (state == DRAIN);
   assign busy       = (state != IDLE);
   assign acc_data   = sum_q;
   assign acc_sat    = sat_q;

endmodule

// File: tb/tb_pe_accumulator.sv
// Randomized self-checking bench for pe_accumulator against a sum/clamp model.
module tb_pe_accumulator;
   import pe_pkg::*;

   localparam int DW = 8;
   localparam int AW = 32;
   localparam int LW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          start, prod_valid, prod_ready, acc_valid, acc_sat, acc_ready, busy;
   logic [LW-1:0] len;
   logic [2*DW-1:0] prod_data;
   logic [AW-1:0] acc_data;

   logic          b_start, b_pv, b_pr, b_av, b_as, b_ar, b_busy;
   logic [LW-1:0] b_len;
   logic [15:0]   b_pd;
   logic [15:0]   b_ad;

   pe_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
      .acc_valid(acc_valid), .acc_data(acc_data), .acc_sat(acc_sat),
      .acc_ready(acc_ready), .busy(busy)
   );

   pe_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(LW)) dut16 (
      .clk(clk), .rst(rst), .start(b_start), .len(b_len),
      .prod_valid(b_pv), .prod_data(b_pd), .prod_ready(b_pr),
      .acc_valid(b_av), .acc_data(b_ad), .acc_sat(b_as),
      .acc_ready(b_ar), .busy(b_busy)
   );

   int n_chk = 0;
   int n_pass = 0;

   int d_q[$];
   bit v_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint clamp(input longint s, input int aw);
      longint mx;
      mx = (longint'(1) << aw) - 1;
      return (s > mx) ? mx : s;
   endfunction

   // One full transaction on the 32-bit instance: start, n beats, hold, drain.
   task automatic run_txn(input int n, input bit rnd_gap, input int hold, input string tag);
      longint s;
      int got, cyc;
      bit v;
      logic [15:0] d;
      logic [AW-1:0] held;
      s = 0; got = 0; cyc = 0;
      start = 1'b1; len = LW'(n);
      step();
      start = 1'b0;
      chk({tag, ".busy"}, busy, 1);
      while (got < n && cyc < 4 * n + 100) begin
         chk({tag, ".pready"}, prod_ready, 1);
         chk({tag, ".avalid0"}, acc_valid, 0);
         chk({tag, ".sum"}, acc_data, clamp(s, AW));
         if (v_q.size() > 0) v = v_q.pop_front();
         else v = rnd_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
         d = $urandom;
         if (v && d_q.size() > 0) d = 16'(d_q.pop_front());
         prod_valid = v; prod_data = d;
         if (v) begin s += d; got++; end
         step();
         cyc++;
      end
      prod_valid = 1'b0;
      if (got < n) chk({tag, ".timeout"}, got, n);
      chk({tag, ".avalid"}, acc_valid, 1);
      chk({tag, ".adata"}, acc_data, clamp(s, AW));
      chk({tag, ".asat"}, acc_sat, (s > clamp(s, AW)) ? 1 : 0);
      chk({tag, ".pready0"}, prod_ready, 0);
      held = acc_data;
      for (int i = 0; i < hold; i++) begin
         acc_ready = 1'b0;
         start = $urandom; prod_valid = $urandom; len = $urandom; prod_data = $urandom;
         step();
         chk({tag, ".hold_v"}, acc_valid, 1);
         chk({tag, ".hold_d"}, acc_data, clamp(s, AW));
         chk({tag, ".hold_busy"}, busy, 1);
         chk({tag, ".hold_pr"}, prod_ready, 0);
      end
      start = 1'b1; prod_valid = 1'b0; acc_ready = 1'b1;
      step();
      start = 1'b0; acc_ready = 1'b0;
      chk({tag, ".idle"}, busy, 0);
      chk({tag, ".avalid_off"}, acc_valid, 0);
      chk({tag, ".idle_data"}, acc_data, clamp(s, AW));
   endtask

   initial begin
      rst = 1'b0;
      start = 0; len = '0; prod_valid = 0; prod_data = '0; acc_ready = 0;
      b_start = 0; b_len = '0; b_pv = 0; b_pd = '0; b_ar = 0;
      #2;
      chk("rst.pready", prod_ready, 0);
      chk("rst.avalid", acc_valid, 0);
      chk("rst.adata", acc_data, 0);
      chk("rst.asat", acc_sat, 0);
      chk("rst.busy", busy, 0);
      chk("rst16.adata", b_ad, 0);
      step(); step();
      rst = 1'b1;

      // first start right on the first IDLE cycle
      d_q = '{3, 5, 7, 9};
      run_txn(4, 1'b0, 0, "dot4");

      run_txn(0, 1'b0, 1, "len0");

      run_txn(3, 1'b1, 5, "hold5");

      v_q = '{1, 0, 0, 1, 1, 0, 1};
      run_txn(4, 1'b0, 0, "gap");

      for (int t = 0; t < 20; t++)
         run_txn($urandom_range(0, 12), 1'b1, $urandom_range(0, 3), "rnd");

      // saturation on the 16-bit accumulator
      b_start = 1'b1; b_len = 3;
      step();
      b_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("sat16.pready", b_pr, 1);
         b_pv = 1'b1; b_pd = 16'd65025;
         step();
      end
      b_pv = 1'b0;
      chk("sat16.avalid", b_av, 1);
      chk("sat16.adata", b_ad, 16'hFFFF);
      chk("sat16.asat", b_as, 1);
      b_ar = 1'b1;
      step();
      b_ar = 1'b0;
      chk("sat16.idle", b_busy, 0);

      // reset in the middle of an accumulation
      start = 1'b1; len = 4;
      step();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         prod_valid = 1'b1; prod_data = 16'($urandom_range(1, 1000));
         step();
      end
      prod_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst.busy", busy, 0);
      chk("midrst.adata", acc_data, 0);
      chk("midrst.pready", prod_ready, 0);
      chk("midrst.avalid", acc_valid, 0);
      chk("midrst.asat", acc_sat, 0);
      step();
      rst = 1'b1;
      d_q = '{10};
      run_txn(1, 1'b0, 0, "post_rst");

      // maximum length
      run_txn((1 << LW) - 1, 1'b0, 1, "maxlen");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pe_accumulator.md
PE_ACCUMULATOR -- requirements
Module: pe_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: PE operand width; the product input is 2*DATA_WIDTH bits.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: accumulator and result width; ACC_WIDTH >= 2*DATA_WIDTH.
REQ-003 SHALL have parameter LEN_WIDTH, default 16: width of the product-count field.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a dot-product accumulation; sampled only in IDLE.
REQ-007 len  input  LEN_WIDTH  number of products to accumulate; latched with start.
REQ-008 prod_valid  input  1  product beat present.
REQ-009 prod_data  input  2*DATA_WIDTH  unsigned PE product (w*x).
REQ-010 prod_ready  output  1  block accepts a product beat this cycle.
REQ-011 acc_valid  output  1  result available.
REQ-012 acc_data  output  ACC_WIDTH  accumulated sum.
REQ-013 acc_sat  output  1  the sum saturated during this accumulation; valid with acc_valid.
REQ-014 acc_ready  input  1  downstream accepts the result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, ACCUM and DRAIN.
REQ-017 IDLE: start=1 SHALL latch len into the remaining counter, clear the sum and saturation flag, and go to ACCUM, or to DRAIN if len==0.
REQ-018 start SHALL be ignored in ACCUM and DRAIN, with no effect on the latched len or the sum.
REQ-019 prod_ready SHALL be 1 exactly when the state is ACCUM; it is a registered-state decode, with no combinational path from prod_valid.
REQ-020 A beat transfers on a cycle with prod_valid=1 and prod_ready=1; each transfer SHALL add zero-extended prod_data to the sum and decrement the remaining counter.
REQ-021 The addition SHALL saturate at 2^ACC_WIDTH-1 and set the sticky saturation flag; the sum SHALL not wrap.
REQ-022 The transfer that brings the remaining counter to 0 SHALL move the state to DRAIN on the next edge; acc_valid SHALL rise in that cycle (1-cycle latency from the last beat).
REQ-023 In DRAIN, acc_valid SHALL be 1 and acc_data and acc_sat SHALL be held stable until acc_ready=1.
REQ-024 On a DRAIN cycle with acc_ready=1 the result SHALL transfer and the state SHALL return to IDLE; start in that same cycle SHALL be ignored.
REQ-025 acc_valid SHALL not depend combinationally on acc_ready.
REQ-026 In IDLE and ACCUM, acc_valid SHALL be 0 and acc_data SHALL show the current sum.
REQ-027 len equal to its maximum value (2^LEN_WIDTH-1) SHALL accumulate exactly that many beats.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, sum 0, remaining counter 0 and saturation flag 0.
REQ-029 During reset, outputs SHALL be prod_ready=0, acc_valid=0, acc_data=0, acc_sat=0 and busy=0.
REQ-030 Reset asserted mid-ACCUM or mid-DRAIN SHALL discard the partial result, with no output transfer.
REQ-031 After reset deasserts, the first start SHALL be accepted in the first IDLE cycle.

Structure
REQ-032 The state enum (IDLE/ACCUM/DRAIN) and the default ACC_WIDTH constant SHALL live in shared package pe_pkg.
REQ-033 Saturating addition SHALL be a sub-module sat_add (combinational, inputs a/b, outputs sum/sat); the control logic stays in pe_accumulator.

Verification
REQ-034 The bench SHALL cover: reset, then start with len=4 and products 3,5,7,9 on back-to-back valid -> acc_valid one cycle after the 4th beat, acc_data=24, acc_sat=0.
REQ-035 The bench SHALL cover: start with len=0 -> acc_valid the next cycle with acc_data=0, and prod_ready never asserted.
REQ-036 The bench SHALL cover: ACC_WIDTH=16, DATA_WIDTH=8, len=3, products 65025 ×3 -> acc_data=65535, acc_sat=1.
REQ-037 The bench SHALL cover: result ready, acc_ready held 0 for 5 cycles while start pulses and prod_valid toggles -> acc_data stable, state unchanged; acc_ready=1 -> IDLE the next cycle.
REQ-038 The bench SHALL cover: len=4, prod_valid gapped (1,0,0,1,1,0,1) -> sum of exactly 4 accepted beats, with no beat counted while prod_valid=0.
REQ-039 The bench SHALL cover: rst driven 0 after 2 of 4 beats -> outputs 0 immediately; a new start with len=1, product 10 -> acc_data=10.
